serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial subtractor: computes diff = a - b - b_in, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the subtract-direction counterpart of the team's ripple-carry adder datapath.
- It trades latency for area: WIDTH cycles per operation instead of a WIDTH-deep combinational borrow chain.
- Used by the lab ALU as a multi-cycle SUB/CMP unit behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  minuend; captured on accepted start
- b  in  WIDTH  subtrahend; captured on accepted start
- b_in  in  1  borrow-in; captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid
- diff  out  WIDTH  a - b - b_in modulo 2^WIDTH; held until the next accepted start
- b_out  out  1  borrow-out (1 when unsigned a < b + b_in)
- ovf  out  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, b_out=0, ovf=0; shift registers, counter and borrow FF cleared. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k:
  - latch a into sa and b into sb;
  - borrow FF = b_in;
  - cnt=0; result shift register cleared;
  - record sign bits a[WIDTH-1] and b[WIDTH-1];
  - go to RUN; busy=1 from edge k.
- RUN, each edge:
  - d = sa[0]^sb[0]^br
  - br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - result shifts right with d inserted at the MSB; sa and sb shift right; cnt++.
- RUN exit: on the edge where cnt==WIDTH-1, i.e. edge k+WIDTH:
  - go to DONE;
  - diff = final result; b_out = final br_next;
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
  - busy=0, done=1.
- Latency: done is high exactly WIDTH cycles after the start-accept edge.
- DONE lasts one cycle:
  - start=1: accepted exactly as in IDLE (back-to-back operation); done drops, busy rises.
  - otherwise: go to IDLE, done=0.
- start while RUN: ignored. a, b and b_in may change freely during RUN without affecting the result.
- diff, b_out and ovf are registered and hold their values through IDLE. They are not cleared by a new start; they update only at completion.
- Counter width: $clog2(WIDTH). No wrap is possible because the counter is reset on each start.

Decomposition:
- Package serial_sub_pkg:
  - state enum {S_IDLE, S_RUN, S_DONE} (2-bit encoding);
  - DEFAULT_WIDTH=8.
- Sub-module one_bit_sub:
  - combinational full subtractor (x, y, bin -> d, bout);
  - instantiated once in RUN datapath;
  - reusable by a later parallel ripple-borrow subtractor.

Test Plan:
- a=0x05, b=0x03, b_in=0 -> done 8 cycles after accept; diff=0x02, b_out=0, ovf=0; busy high for exactly 8 cycles.
- a=0x00, b=0x01, b_in=0 -> diff=0xFF, b_out=1, ovf=0; then a=0x80, b=0x01 -> diff=0x7F, b_out=0, ovf=1.
- a=0x10, b=0x10, b_in=1 -> diff=0xFF, b_out=1, ovf=0; a=0x7F, b=0xFF, b_in=0 -> diff=0x80, ovf=1, b_out=1.
- start re-pulsed and a/b changed mid-RUN -> ignored; original result produced; start held high in the DONE cycle -> second operation accepted, done pulses again 8 cycles later.
- rst asserted at cycle 4 of RUN -> all outputs 0 immediately (async), no done; the next start completes normally.
- Randomised check (1000 ops, WIDTH=8 and WIDTH=16): compare diff, b_out and ovf against the behavioural model {b_out,diff} = a - b - b_in.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/one_bit_sub.sv
// Combinational full subtractor: d = x - y - bin, with borrow-out.
module one_bit_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first,
// behind a start/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg, res_reg, diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg, a_msb_reg, b_msb_reg, b_out_reg, ovf_reg;
  logic             accept, last;
  logic             bit_d, bit_bout;
  logic [WIDTH-1:0] res_next;

  one_bit_sub u_cell (
    .x    (sa_reg[0]),
    .y    (sb_reg[0]),
    .bin  (br_reg),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign res_next = {bit_d, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start in the completion cycle chains straight into the next op.
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_reg    <= '0;
      sb_reg    <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      diff_reg  <= '0;
      b_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      sa_reg    <= a;
      sb_reg    <= b;
      res_reg   <= '0;
      cnt_reg   <= '0;
      br_reg    <= b_in;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if (state_reg == S_RUN) begin
      sa_reg  <= {1'b0, sa_reg[WIDTH-1:1]};
      sb_reg  <= {1'b0, sb_reg[WIDTH-1:1]};
      res_reg <= res_next;
      br_reg  <= bit_bout;
      cnt_reg <= cnt_reg + 1'b1;
      // Published results only change here, so they hold through IDLE.
      if (last) begin
        diff_reg  <= res_next;
        b_out_reg <= bit_bout;
        ovf_reg   <= (a_msb_reg != b_msb_reg) && (bit_d != a_msb_reg);
      end
    end
  end

  assign diff  = diff_reg;
  assign b_out = b_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, bi8, busy8, done8, bo8, ovf8;
  logic [7:0]  a8, b8, d8;
  logic        start16, bi16, busy16, done16, bo16, ovf16;
  logic [15:0] a16, b16, d16;

  logic [7:0]  ea8, eb8;
  logic        ebi8;

  int checks_total  = 0;
  int checks_passed = 0;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .diff(d8), .b_out(bo8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .b_in(bi16),
    .busy(busy16), .done(done16), .diff(d16), .b_out(bo16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Plain integer arithmetic: unsigned difference for diff/borrow, signed
  // range test for overflow.
  function automatic void model(input int w, input longint ua, input longint ub, input bit bi,
                                output longint d, output bit bo, output bit ov);
    longint one = 1;
    longint r   = ua - ub - longint'(bi);
    longint half = one <<< (w - 1);
    longint full = one <<< w;
    longint sa  = (ua >= half) ? ua - full : ua;
    longint sb  = (ub >= half) ? ub - full : ub;
    longint s   = sa - sb - longint'(bi);
    bo = (r < 0);
    d  = (r < 0) ? r + full : r;
    ov = (s < -half) || (s >= half);
  endfunction

  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    @(negedge clk);
    a8 = a; b8 = b; bi8 = bi; start8 = 1'b1;
    ea8 = a; eb8 = b; ebi8 = bi;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("accept.busy", busy8, 1'b1);
    check("accept.done", done8, 1'b0);
  endtask

  task automatic finish8_op(input string tag, input bit perturb);
    int lat = 0;
    int bcnt = 0;
    longint ed;
    bit ebo, eov;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      if (perturb && lat == 3) begin
        start8 = 1'b1; a8 = ~a8; b8 = 8'($urandom); bi8 = ~bi8;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    model(8, longint'(ea8), longint'(eb8), ebi8, ed, ebo, eov);
    check({tag, ".latency"}, lat, 8);
    check({tag, ".busy_cycles"}, bcnt, 8);
    check({tag, ".diff"}, d8, ed);
    check({tag, ".b_out"}, bo8, ebo);
    check({tag, ".ovf"}, ovf8, eov);
    $display("op8 %s a=%02h b=%02h bin=%0d -> diff=%02h b_out=%0d ovf=%0d",
             tag, ea8, eb8, ebi8, d8, bo8, ovf8);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi);
    start8_op(a, b, bi);
    finish8_op(tag, 1'b0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int lat = 0;
    longint ed;
    bit ebo, eov;
    @(negedge clk);
    a16 = a; b16 = b; bi16 = bi; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    model(16, longint'(a), longint'(b), bi, ed, ebo, eov);
    check("rand16.latency", lat, 16);
    check("rand16.diff", d16, ed);
    check("rand16.b_out", bo16, ebo);
    check("rand16.ovf", ovf16, eov);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bi16 = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset.busy", busy8, 1'b0);
    check("reset.done", done8, 1'b0);
    check("reset.diff", d8, 8'h00);
    check("reset.b_out", bo8, 1'b0);
    check("reset.ovf", ovf8, 1'b0);
    check("reset.busy16", busy16, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    op8("basic", 8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    check("basic.done_pulse", done8, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("basic.diff_hold", d8, 8'h02);

    op8("under", 8'h00, 8'h01, 1'b0);
    op8("sovf", 8'h80, 8'h01, 1'b0);
    op8("bin_eq", 8'h10, 8'h10, 1'b1);
    op8("sovf_neg", 8'h7F, 8'hFF, 1'b0);

    start8_op(8'h3C, 8'h15, 1'b0);
    finish8_op("perturb", 1'b1);
    // Issue the next start during the DONE cycle.
    start8_op(8'hA5, 8'h5A, 1'b1);
    finish8_op("b2b", 1'b0);

    op8("pre_rst", 8'h7F, 8'hFF, 1'b0);
    start8_op(8'h55, 8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", busy8, 1'b0);
    check("midrst.done", done8, 1'b0);
    check("midrst.diff", d8, 8'h00);
    check("midrst.b_out", bo8, 1'b0);
    check("midrst.ovf", ovf8, 1'b0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen = 1;
    end
    check("midrst.no_done", seen, 0);
    op8("post_rst", 8'hC3, 8'h3C, 1'b1);

    for (int i = 0; i < 1000; i++)
      op8("rand8", 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    $display("rand16 ops complete");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
